// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
// The BCD-to-seconds helper keeps total_seconds arithmetic in one place.
package stopwatch_pkg;

    localparam int MAX_MIN_DEF  = 99;
    localparam int SEC_W_DEF    = 13;
    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX    = 9;

    typedef logic [3:0] bcd_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        PAUSE  = 3'd2,
        ADJUST = 3'd3,
        FULL   = 3'd4
    } state_e;

    function automatic logic [15:0] bcd_to_seconds(bcd_t min_tens, bcd_t min_ones,
                                                   bcd_t sec_tens, bcd_t sec_ones);
        return 16'(min_tens) * 16'd600 + 16'(min_ones) * 16'd60 +
               16'(sec_tens) * 16'd10 + 16'(sec_ones);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control/status bundle between the stopwatch controller and its neighbours.
// Inputs are one-cycle pulses (ticks, buttons) or levels (adj_en, adj_sel); no back-pressure exists.
interface stopwatch_ctrl_if #(
    parameter int SEC_W = stopwatch_pkg::SEC_W_DEF
);
    import stopwatch_pkg::*;

    logic             tick_1hz;
    logic             tick_adj;
    logic             btn_reset;
    logic             btn_pause;
    logic             adj_en;
    logic             adj_sel;
    bcd_t             min_tens;
    bcd_t             min_ones;
    bcd_t             sec_tens;
    bcd_t             sec_ones;
    logic [SEC_W-1:0] total_seconds;
    logic             running;
    logic             blink;
    state_e           dbg_state;

    modport master (
        output tick_1hz, tick_adj, btn_reset, btn_pause, adj_en, adj_sel,
        input  min_tens, min_ones, sec_tens, sec_ones, total_seconds, running, blink, dbg_state
    );

    modport slave (
        input  tick_1hz, tick_adj, btn_reset, btn_pause, adj_en, adj_sel,
        output min_tens, min_ones, sec_tens, sec_ones, total_seconds, running, blink, dbg_state
    );

endinterface

// File: rtl/stopwatch_ctrl_bcd_digit_counter.sv
// One registered BCD digit with wrap at MODULUS-1 and a ripple carry.
// next_o exposes the value the digit will take, so sums can be registered alongside it.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MODULUS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output bcd_t digit_o,
    output bcd_t next_o,
    output logic carry_o
);

    localparam bcd_t DMAX = bcd_t'(MODULUS - 1);

    bcd_t digit_q;
    bcd_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = '0;
        end else if (inc_i) begin
            // Out-of-range values also wrap to zero rather than counting on.
            digit_d = (digit_q >= DMAX) ? '0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign next_o  = digit_d;
    assign carry_o = inc_i & (digit_q == DMAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: run/pause/adjust/full FSM driving a chained MM:SS BCD count.
// All outputs are registered; total_seconds is derived from the next-state digits.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = MAX_MIN_DEF,
    parameter int SEC_W   = SEC_W_DEF
) (
    input logic             clk,
    input logic             rst,
    stopwatch_ctrl_if.slave sw
);

    localparam bcd_t MT_MAX = bcd_t'(MAX_MIN / 10);
    localparam bcd_t MO_MAX = bcd_t'(MAX_MIN % 10);
    localparam bcd_t ST_MAX = bcd_t'(SEC_TENS_MAX);
    localparam bcd_t SO_MAX = bcd_t'(DIGIT_MAX);

    state_e           state_q, state_d;
    logic             blink_q, blink_d;
    logic             running_q;
    logic [SEC_W-1:0] total_q, total_d;

    logic cnt_inc;
    logic adj_sec_inc;
    logic adj_min_inc;
    logic adj_min_wrap;
    logic clr_all;

    bcd_t so_q, st_q, mo_q, mt_q;
    bcd_t so_n, st_n, mo_n, mt_n;
    logic so_carry, st_carry, mo_carry;
    logic unused_mt_carry;

    logic at_max_min;
    logic at_full;

    assign at_max_min = (mt_q == MT_MAX) && (mo_q == MO_MAX);
    assign at_full    = at_max_min && (st_q == ST_MAX) && (so_q == SO_MAX);

    always_comb begin
        state_d      = state_q;
        blink_d      = blink_q;
        cnt_inc      = 1'b0;
        adj_sec_inc  = 1'b0;
        adj_min_inc  = 1'b0;
        adj_min_wrap = 1'b0;
        clr_all      = 1'b0;

        if (sw.btn_reset) begin
            clr_all = 1'b1;
            state_d = IDLE;
            blink_d = 1'b0;
        end else if (sw.adj_en) begin
            state_d = ADJUST;
            // The entry cycle only changes state; adjust ticks act once in ADJUST.
            if (state_q == ADJUST && sw.tick_adj) begin
                blink_d = ~blink_q;
                if (sw.adj_sel) begin
                    if (at_max_min) begin
                        adj_min_wrap = 1'b1;
                    end else begin
                        adj_min_inc = 1'b1;
                    end
                end else begin
                    adj_sec_inc = 1'b1;
                end
            end
        end else begin
            case (state_q)
                IDLE, PAUSE: begin
                    if (sw.btn_pause) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (sw.btn_pause) begin
                        state_d = PAUSE;
                    end else if (sw.tick_1hz) begin
                        if (at_full) begin
                            state_d = FULL;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                ADJUST: begin
                    state_d = PAUSE;
                    blink_d = 1'b0;
                end
                FULL: begin
                    state_d = FULL;
                end
                default: begin
                    state_d = IDLE;
                    blink_d = 1'b0;
                end
            endcase
        end
    end

    // Seconds carry into minutes only while counting, never while adjusting.
    bcd_digit_counter #(.MODULUS(DIGIT_MAX + 1)) u_sec_ones (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (cnt_inc | adj_sec_inc),
        .clr_i   (clr_all),
        .digit_o (so_q),
        .next_o  (so_n),
        .carry_o (so_carry)
    );

    bcd_digit_counter #(.MODULUS(SEC_TENS_MAX + 1)) u_sec_tens (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (so_carry),
        .clr_i   (clr_all),
        .digit_o (st_q),
        .next_o  (st_n),
        .carry_o (st_carry)
    );

    bcd_digit_counter #(.MODULUS(DIGIT_MAX + 1)) u_min_ones (
        .clk     (clk),
        .rst     (rst),
        .inc_i   ((st_carry & cnt_inc) | adj_min_inc),
        .clr_i   (clr_all | adj_min_wrap),
        .digit_o (mo_q),
        .next_o  (mo_n),
        .carry_o (mo_carry)
    );

    bcd_digit_counter #(.MODULUS(MAX_MIN / 10 + 1)) u_min_tens (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (mo_carry),
        .clr_i   (clr_all | adj_min_wrap),
        .digit_o (mt_q),
        .next_o  (mt_n),
        .carry_o (unused_mt_carry)
    );

    assign total_d = SEC_W'(bcd_to_seconds(mt_n, mo_n, st_n, so_n));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            blink_q   <= 1'b0;
            running_q <= 1'b0;
            total_q   <= '0;
        end else begin
            state_q   <= state_d;
            blink_q   <= blink_d;
            running_q <= (state_d == RUN);
            total_q   <= total_d;
        end
    end

    assign sw.min_tens      = mt_q;
    assign sw.min_ones      = mo_q;
    assign sw.sec_tens      = st_q;
    assign sw.sec_ones      = so_q;
    assign sw.total_seconds = total_q;
    assign sw.running       = running_q;
    assign sw.blink         = blink_q;
    assign sw.dbg_state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed plus short random bench for stopwatch_ctrl with an integer reference model.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int W = 34;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    stopwatch_ctrl_if #(.SEC_W(13)) sw ();

    stopwatch_ctrl #(.MAX_MIN(99), .SEC_W(13)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw)
    );

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    int     m_min;
    int     m_sec;
    state_e m_st;
    logic   m_blink;

    function automatic logic [W-1:0] pack(state_e st, int mins, int secs, logic bl);
        logic run;
        run = (st == RUN);
        return {3'(st), run, bl, 4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
                13'(mins * 60 + secs)};
    endfunction

    function automatic logic [W-1:0] observed();
        return {3'(sw.dbg_state), sw.running, sw.blink, sw.min_tens, sw.min_ones,
                sw.sec_tens, sw.sec_ones, sw.total_seconds};
    endfunction

    task automatic compare(input string tag);
        logic [W-1:0] e;
        logic [W-1:0] o;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s observed=no_expectation expected=queued_value", tag);
        end else begin
            e = exp_q.pop_front();
            o = observed();
            assert (o === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, o, e);
            end
        end
    endtask

    // Stopwatch behaviour in minutes/seconds integers, evaluated on the pre-edge state.
    task automatic model(input bit r, input bit brst, input bit bp, input bit t1, input bit ta);
        if (r || brst) begin
            m_min = 0; m_sec = 0; m_st = IDLE; m_blink = 1'b0;
        end else if (sw.adj_en) begin
            if (m_st == ADJUST && ta) begin
                m_blink = ~m_blink;
                if (sw.adj_sel) m_min = (m_min == 99) ? 0 : m_min + 1;
                else            m_sec = (m_sec == 59) ? 0 : m_sec + 1;
            end
            m_st = ADJUST;
        end else begin
            case (m_st)
                ADJUST: begin m_st = PAUSE; m_blink = 1'b0; end
                IDLE, PAUSE: if (bp) m_st = RUN;
                RUN: begin
                    if (bp) m_st = PAUSE;
                    else if (t1) begin
                        if (m_min == 99 && m_sec == 59) m_st = FULL;
                        else begin
                            m_sec++;
                            if (m_sec == 60) begin m_sec = 0; m_min++; end
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input string tag, input bit r, input bit brst, input bit bp,
                        input bit t1, input bit ta);
        rst          = r;
        sw.btn_reset = brst;
        sw.btn_pause = bp;
        sw.tick_1hz  = t1;
        sw.tick_adj  = ta;
        model(r, brst, bp, t1, ta);
        exp_q.push_back(pack(m_st, m_min, m_sec, m_blink));
        @(posedge clk);
        #1;
        rst          = 1'b0;
        sw.btn_reset = 1'b0;
        sw.btn_pause = 1'b0;
        sw.tick_1hz  = 1'b0;
        sw.tick_adj  = 1'b0;
        compare(tag);
    endtask

    task automatic expect_const(input string tag, input state_e st, input int mins,
                                input int secs, input logic bl);
        exp_q.push_back(pack(st, mins, secs, bl));
        compare(tag);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step("tick", 0, 0, 0, 1, 0);
            repeat ($urandom_range(0, 2)) step("gap", 0, 0, 0, 0, 0);
        end
    endtask

    task automatic adj_ticks(input int n);
        for (int i = 0; i < n; i++) step("adj_tick", 0, 0, 0, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        sw.btn_reset = 1'b0; sw.btn_pause = 1'b0; sw.tick_1hz = 1'b0;
        sw.tick_adj = 1'b0; sw.adj_en = 1'b0; sw.adj_sel = 1'b0;
        m_min = 0; m_sec = 0; m_st = IDLE; m_blink = 1'b0;

        step("reset", 1, 0, 0, 0, 0);
        step("reset", 1, 0, 0, 0, 0);
        expect_const("reset_state", IDLE, 0, 0, 1'b0);
        step("idle_tick", 0, 0, 0, 1, 0);
        expect_const("idle_tick_discard", IDLE, 0, 0, 1'b0);

        step("start", 0, 0, 1, 0, 0);
        ticks(75);
        expect_const("run_01_15", RUN, 1, 15, 1'b0);

        step("clr", 0, 1, 0, 0, 0);
        step("start", 0, 0, 1, 0, 0);
        ticks(59);
        expect_const("at_00_59", RUN, 0, 59, 1'b0);
        ticks(1);
        expect_const("carry_01_00", RUN, 1, 0, 1'b0);

        step("clr", 0, 1, 0, 0, 0);
        sw.adj_en = 1'b1;
        step("enter_adj", 0, 0, 0, 0, 0);
        sw.adj_sel = 1'b1; adj_ticks(9);
        sw.adj_sel = 1'b0; adj_ticks(59);
        expect_const("adj_09_59", ADJUST, 9, 59, 1'b0);
        sw.adj_en = 1'b0;
        step("adj_release", 0, 0, 0, 0, 0);
        expect_const("released_pause", PAUSE, 9, 59, 1'b0);
        step("start", 0, 0, 1, 0, 0);
        ticks(1);
        expect_const("carry_10_00", RUN, 10, 0, 1'b0);

        step("clr", 0, 1, 0, 0, 0);
        sw.adj_en = 1'b1;
        step("enter_adj", 0, 0, 0, 0, 0);
        sw.adj_sel = 1'b1; adj_ticks(99);
        sw.adj_sel = 1'b0; adj_ticks(58);
        expect_const("adj_99_58", ADJUST, 99, 58, 1'b1);
        sw.adj_en = 1'b0;
        step("adj_release", 0, 0, 0, 0, 0);
        step("start", 0, 0, 1, 0, 0);
        ticks(1);
        expect_const("run_99_59", RUN, 99, 59, 1'b0);
        ticks(1);
        expect_const("full", FULL, 99, 59, 1'b0);
        ticks(1);
        step("full_pause", 0, 0, 1, 0, 0);
        expect_const("full_hold", FULL, 99, 59, 1'b0);

        sw.adj_en = 1'b1;
        step("enter_adj", 0, 0, 0, 0, 0);
        sw.adj_sel = 1'b1; adj_ticks(1);
        expect_const("min_wrap", ADJUST, 0, 59, 1'b1);
        sw.adj_sel = 1'b0; adj_ticks(59);
        expect_const("adj_00_58", ADJUST, 0, 58, 1'b0);
        adj_ticks(3);
        expect_const("sec_wrap_no_carry", ADJUST, 0, 1, 1'b1);
        step("adj_ignore", 0, 0, 1, 1, 0);
        expect_const("adj_ignores_run", ADJUST, 0, 1, 1'b1);
        step("reset_in_adj", 0, 1, 0, 0, 0);
        expect_const("reset_in_adj", IDLE, 0, 0, 1'b0);
        step("readjust", 0, 0, 0, 0, 0);
        expect_const("readjust", ADJUST, 0, 0, 1'b0);

        sw.adj_sel = 1'b1; adj_ticks(5);
        sw.adj_sel = 1'b0; adj_ticks(7);
        sw.adj_en = 1'b0;
        step("adj_release", 0, 0, 0, 0, 0);
        step("start", 0, 0, 1, 0, 0);
        expect_const("run_05_07", RUN, 5, 7, 1'b0);
        step("combo", 0, 1, 1, 1, 0);
        expect_const("combo_reset", IDLE, 0, 0, 1'b0);

        step("start", 0, 0, 1, 0, 0);
        ticks(10);
        expect_const("run_00_10", RUN, 0, 10, 1'b0);
        step("rst_tick", 1, 0, 0, 1, 0);
        expect_const("rst_clears", IDLE, 0, 0, 1'b0);

        sw.adj_en = 1'b1;
        step("enter_adj", 0, 0, 0, 0, 0);
        adj_ticks(1);
        sw.adj_en = 1'b0;
        step("rst_blink", 1, 0, 0, 0, 0);
        expect_const("rst_blink", IDLE, 0, 0, 1'b0);

        step("start", 0, 0, 1, 0, 0);
        ticks(3);
        step("pause", 0, 0, 1, 0, 0);
        expect_const("paused", PAUSE, 0, 3, 1'b0);
        step("pause_tick", 0, 0, 0, 1, 0);
        expect_const("pause_tick", PAUSE, 0, 3, 1'b0);
        step("resume", 0, 0, 1, 0, 0);
        ticks(1);
        expect_const("resume", RUN, 0, 4, 1'b0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) sw.adj_en = ~sw.adj_en;
            sw.adj_sel = 1'($urandom_range(0, 1));
            step("random", 0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
